// File: rtl/nfc_pkg.sv
// Shared types and defaults for the NAND buffer transfer sequencer.
package nfc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WE_LOW,
    WE_HIGH,
    RE_LOW,
    RE_HIGH,
    DONE
  } xfer_state_t;

  localparam logic DIR_PROG = 1'b0;
  localparam logic DIR_READ = 1'b1;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_T_WP   = 2;
  localparam int unsigned DEF_T_WH   = 2;
  localparam int unsigned DEF_T_RP   = 2;
  localparam int unsigned DEF_T_REH  = 2;
  localparam int unsigned TIMER_W    = 8;

endpackage

// File: rtl/nfc_strobe_timer.sv
// Loadable down counter that times every strobe phase; saturates at zero.
module nfc_strobe_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/nfc_buffer_xfer.sv
// Moves bytes between the page-buffer RAM port and the NAND I/O bus,
// generating WE_n strobes for program and RE_n strobes for read.
module nfc_buffer_xfer
  import nfc_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned T_WP   = DEF_T_WP,
  parameter int unsigned T_WH   = DEF_T_WH,
  parameter int unsigned T_RP   = DEF_T_RP,
  parameter int unsigned T_REH  = DEF_T_REH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W:0]   byte_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_rd_en,
  input  logic [7:0]        buf_rd_data,
  output logic              buf_wr_en,
  output logic [7:0]        buf_wr_data,
  output logic [7:0]        io_out,
  output logic              io_oe,
  input  logic [7:0]        io_in,
  output logic              we_n,
  output logic              re_n
);

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  xfer_state_t         state, next_state;
  logic [ADDR_W:0]     count_q, index, index_d;
  logic                last_byte;
  logic                tmr_load, tmr_zero;
  logic [TIMER_W-1:0]  tmr_load_value, tmr_value;
  logic                unused_tmr;
  logic                we_n_d, re_n_d, io_oe_d, buf_rd_en_d, buf_wr_en_d, busy_d, done_d;
  logic [ADDR_W-1:0]   buf_addr_d;

  nfc_strobe_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .zero       (tmr_zero)
  );

  assign unused_tmr = ^tmr_value;
  assign last_byte  = (index == count_q - IDX_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      index       <= '0;
      count_q     <= '0;
      we_n        <= 1'b1;
      re_n        <= 1'b1;
      io_oe       <= 1'b0;
      io_out      <= '0;
      buf_rd_en   <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_data <= '0;
      buf_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state     <= next_state;
      index     <= index_d;
      we_n      <= we_n_d;
      re_n      <= re_n_d;
      io_oe     <= io_oe_d;
      buf_rd_en <= buf_rd_en_d;
      buf_wr_en <= buf_wr_en_d;
      buf_addr  <= buf_addr_d;
      busy      <= busy_d;
      done      <= done_d;
      if (state == IDLE && start) count_q <= byte_count;
      if (state == LATCH) io_out <= buf_rd_data;
      if (buf_wr_en_d) buf_wr_data <= io_in;
    end
  end

  // Direction is implied by the path taken out of IDLE, so it needs no register.
  always_comb begin
    next_state     = state;
    index_d        = index;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    case (state)
      IDLE: begin
        if (start) begin
          index_d = '0;
          if (byte_count == '0) begin
            next_state = DONE;
          end else if (dir == DIR_READ) begin
            next_state     = RE_LOW;
            tmr_load       = 1'b1;
            tmr_load_value = TIMER_W'(T_RP - 1);
          end else begin
            next_state = FETCH;
          end
        end
      end
      FETCH: next_state = LATCH;
      LATCH: begin
        next_state     = WE_LOW;
        tmr_load       = 1'b1;
        tmr_load_value = TIMER_W'(T_WP - 1);
      end
      WE_LOW: begin
        if (tmr_zero) begin
          next_state     = WE_HIGH;
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(T_WH - 1);
        end
      end
      WE_HIGH: begin
        if (tmr_zero) begin
          if (last_byte) begin
            next_state = DONE;
          end else begin
            index_d    = index + IDX_ONE;
            next_state = FETCH;
          end
        end
      end
      RE_LOW: begin
        if (tmr_zero) begin
          next_state     = RE_HIGH;
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(T_REH - 1);
        end
      end
      RE_HIGH: begin
        if (tmr_zero) begin
          if (last_byte) begin
            next_state = DONE;
          end else begin
            index_d        = index + IDX_ONE;
            next_state     = RE_LOW;
            tmr_load       = 1'b1;
            tmr_load_value = TIMER_W'(T_RP - 1);
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one is a
  // glitch-free flop that tracks the current state exactly.
  always_comb begin
    we_n_d      = (next_state != WE_LOW);
    re_n_d      = (next_state != RE_LOW);
    io_oe_d     = (next_state inside {LATCH, WE_LOW, WE_HIGH}) ||
                  (next_state == FETCH && state == WE_HIGH);
    buf_rd_en_d = (next_state == FETCH);
    buf_wr_en_d = (next_state == RE_HIGH) && (state == RE_LOW);
    busy_d      = (next_state != IDLE);
    done_d      = (next_state == DONE);
    buf_addr_d  = (buf_rd_en_d || buf_wr_en_d) ? index_d[ADDR_W-1:0] : buf_addr;
  end

endmodule

// File: tb/tb_nfc_buffer_xfer.sv
// Directed bench for nfc_buffer_xfer: default-timing instance plus one with T_WP=1, T_REH=3.
module tb_nfc_buffer_xfer;

  localparam int unsigned AW = 11;

  typedef struct {
    bit s;         // 0: default instance, 1: overridden-timing instance
    bit d;         // direction
    int cnt;
    int exp_done;  // cycle (start cycle = 0) in which done is high
    int exp_oe;    // number of cycles io_oe is high
    int exp_low;   // active strobe low width
    int exp_per;   // falling-edge to falling-edge period
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, dir, sel;
  logic [AW:0]   byte_count;
  logic [7:0]    io_in, buf_rd_data;
  logic          start0, start1;

  logic          busy0, done0, rd0, wr0, oe0, we0, re0;
  logic [AW-1:0] addr0;
  logic [7:0]    wd0, out0;
  logic          busy1, done1, rd1, wr1, oe1, we1, re1;
  logic [AW-1:0] addr1;
  logic [7:0]    wd1, out1;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  nfc_buffer_xfer dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .dir(dir), .byte_count(byte_count),
    .busy(busy0), .done(done0), .buf_addr(addr0), .buf_rd_en(rd0),
    .buf_rd_data(buf_rd_data), .buf_wr_en(wr0), .buf_wr_data(wd0),
    .io_out(out0), .io_oe(oe0), .io_in(io_in), .we_n(we0), .re_n(re0)
  );

  nfc_buffer_xfer #(.T_WP(1), .T_REH(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start1), .dir(dir), .byte_count(byte_count),
    .busy(busy1), .done(done1), .buf_addr(addr1), .buf_rd_en(rd1),
    .buf_rd_data(buf_rd_data), .buf_wr_en(wr1), .buf_wr_data(wd1),
    .io_out(out1), .io_oe(oe1), .io_in(io_in), .we_n(we1), .re_n(re1)
  );

  logic          m_busy, m_done, m_rd, m_wr, m_oe, m_we, m_re;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wd, m_out;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_rd   = sel ? rd1   : rd0;
  assign m_wr   = sel ? wr1   : wr0;
  assign m_oe   = sel ? oe1   : oe0;
  assign m_we   = sel ? we1   : we0;
  assign m_re   = sel ? re1   : re0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_wd   = sel ? wd1   : wd0;
  assign m_out  = sel ? out1  : out0;

  // Synchronous buffer RAM model: data valid the cycle after the read strobe.
  logic [7:0] mem [0:2047];
  always @(posedge clk) if (m_rd) buf_rd_data <= mem[m_addr];

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input int k);
    case (k)
      0:       return 8'h11;
      1:       return 8'h22;
      2:       return 8'h33;
      default: return 8'(k * 5 + 1);
    endcase
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    logic [7:0]    cap_q[$];
    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];
    int w_q[$], fall_q[$];
    int done_cyc = -1, busy_cyc = 0, oe_cyc = 0, other_low = 0, overlap = 0;
    int n_pulse = 0, cur_w = 0, unstable = 0, n_rd = 0, wrap = 0, first_rd = -1;
    int bad;
    logic [AW-1:0] last_rd = '0;
    logic prev_s = 1'b1;
    logic s_n, o_n;
    sel = v.s;
    io_in = '0;
    start = 1'b1; dir = v.d; byte_count = (AW+1)'(v.cnt);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= v.exp_done + 20 && done_cyc < 0; cyc++) begin
      s_n = v.d ? m_re : m_we;
      o_n = v.d ? m_we : m_re;
      if (!s_n) begin
        if (prev_s) begin
          n_pulse++;
          fall_q.push_back(cyc);
          cap_q.push_back(m_out);
          cur_w = 0;
          if (v.d) io_in = flash_byte(n_pulse - 1);
        end
        cur_w++;
        if (!v.d && m_out != cap_q[$]) unstable++;
      end else if (!prev_s) begin
        w_q.push_back(cur_w);
        if (!v.d && m_out != cap_q[$]) unstable++;
      end
      prev_s = s_n;
      if (!o_n) other_low++;
      if ((!m_re && m_oe) || (!m_we && !m_re)) overlap++;
      if (m_oe) oe_cyc++;
      if (m_busy) busy_cyc++;
      if (m_rd) begin
        if (n_rd == 0) first_rd = int'(m_addr);
        else if (m_addr <= last_rd) wrap++;
        last_rd = m_addr;
        n_rd++;
      end
      if (m_wr) begin
        wa_q.push_back(m_addr);
        wd_q.push_back(m_wd);
      end
      if (m_done) done_cyc = cyc;
      @(negedge clk);
    end
    chk($sformatf("v%0d_done_cycle", id), done_cyc, v.exp_done);
    chk($sformatf("v%0d_busy_cycles", id), busy_cyc, v.exp_done);
    chk($sformatf("v%0d_idle_after", id), {m_busy, m_done}, 0);
    chk($sformatf("v%0d_pulses", id), n_pulse, v.cnt);
    chk($sformatf("v%0d_other_strobe", id), other_low, 0);
    chk($sformatf("v%0d_overlap", id), overlap, 0);
    chk($sformatf("v%0d_oe_cycles", id), oe_cyc, v.exp_oe);
    bad = 0;
    foreach (w_q[i]) if (w_q[i] != v.exp_low) bad++;
    chk($sformatf("v%0d_bad_widths", id), bad, 0);
    bad = 0;
    for (int i = 1; i < fall_q.size(); i++) if (fall_q[i] - fall_q[i-1] != v.exp_per) bad++;
    chk($sformatf("v%0d_bad_periods", id), bad, 0);
    if (!v.d) begin
      chk($sformatf("v%0d_rd_count", id), n_rd, v.cnt);
      chk($sformatf("v%0d_wr_count", id), wa_q.size(), 0);
      chk($sformatf("v%0d_addr_wrap", id), wrap, 0);
      chk($sformatf("v%0d_io_unstable", id), unstable, 0);
      if (v.cnt > 0) begin
        chk($sformatf("v%0d_first_addr", id), first_rd, 0);
        chk($sformatf("v%0d_last_addr", id), last_rd, v.cnt - 1);
      end
      bad = 0;
      foreach (cap_q[i]) if (cap_q[i] !== mem[i % 2048]) bad++;
      chk($sformatf("v%0d_prog_data", id), bad, 0);
    end else begin
      chk($sformatf("v%0d_wr_count", id), wa_q.size(), v.cnt);
      chk($sformatf("v%0d_rd_count", id), n_rd, 0);
      bad = 0;
      foreach (wa_q[i]) if (wa_q[i] != AW'(i) || wd_q[i] !== flash_byte(i)) bad++;
      chk($sformatf("v%0d_read_data", id), bad, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 4,    25,    23,    2, 6};
    vecs[1] = '{0, 1, 3,    13,    0,     2, 4};
    vecs[2] = '{0, 0, 0,    1,     0,     2, 6};
    vecs[3] = '{0, 1, 0,    1,     0,     2, 4};
    vecs[4] = '{0, 0, 1,    7,     5,     2, 6};
    vecs[5] = '{0, 1, 5,    21,    0,     2, 4};
    vecs[6] = '{1, 0, 3,    16,    14,    1, 5};
    vecs[7] = '{1, 1, 3,    16,    0,     2, 5};
    vecs[8] = '{0, 0, 2048, 12289, 12287, 2, 6};
    vecs[9] = '{0, 0, 2,    13,    11,    2, 6};

    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + i / 256 + 3);
    mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'hFF; mem[3] = 8'h00;

    rst_n = 1'b0; start = 1'b0; dir = 1'b0; sel = 1'b0;
    byte_count = '0; io_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {we0, re0, oe0, rd0, wr0, busy0, done0}, 7'b1100000);
    chk("reset_data", {out0, wd0, addr0}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Extra start mid-transfer, then async reset during WE_LOW of byte 2.
    sel = 1'b0;
    start = 1'b1; dir = 1'b0; byte_count = (AW+1)'(4);
    @(negedge clk);                  // cycle 1: FETCH byte 0
    start = 1'b0;
    repeat (2) @(negedge clk);       // cycle 3: WE_LOW byte 0
    start = 1'b1; dir = 1'b1; byte_count = (AW+1)'(7);
    @(negedge clk);
    start = 1'b0; dir = 1'b0;
    repeat (3) @(negedge clk);       // cycle 7: FETCH byte 1
    chk("mid_rd_en", rd0, 1);
    chk("mid_addr", addr0, 1);
    chk("mid_re_n", re0, 1);
    repeat (2) @(negedge clk);       // cycle 9: WE_LOW byte 1
    chk("mid_we_low", we0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {we0, oe0, busy0}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(9, vecs[9]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
